// File: rtl/axi_lite_slave_regs_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_slave_regs_if
//  Description : AXI4-Lite bus bundle between an interconnect master port and
//                the register-bank responder. The five AXI4-Lite channels
//                (AW, W, B, AR, R) are carried as individual signals. The
//                PROT fields travel with the bus but the responder ignores
//                them.
//  Modports    : slave  - responder side (drives READY on AW/W/AR, VALID on B/R)
//                master - requester side (drives VALID on AW/W/AR, READY on B/R)
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_lite_slave_regs_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Write address channel
    logic [ADDR_WIDTH-1:0]   S_AWADDR;
    logic [2:0]              S_AWPROT;
    logic                    S_AWVALID;
    logic                    S_AWREADY;
    // Write data channel
    logic [DATA_WIDTH-1:0]   S_WDATA;
    logic [DATA_WIDTH/8-1:0] S_WSTRB;
    logic                    S_WVALID;
    logic                    S_WREADY;
    // Write response channel
    logic [1:0]              S_BRESP;
    logic                    S_BVALID;
    logic                    S_BREADY;
    // Read address channel
    logic [ADDR_WIDTH-1:0]   S_ARADDR;
    logic [2:0]              S_ARPROT;
    logic                    S_ARVALID;
    logic                    S_ARREADY;
    // Read data channel
    logic [DATA_WIDTH-1:0]   S_RDATA;
    logic [1:0]              S_RRESP;
    logic                    S_RVALID;
    logic                    S_RREADY;

    modport slave (
        input  S_AWADDR, S_AWPROT, S_AWVALID,
        output S_AWREADY,
        input  S_WDATA, S_WSTRB, S_WVALID,
        output S_WREADY,
        output S_BRESP, S_BVALID,
        input  S_BREADY,
        input  S_ARADDR, S_ARPROT, S_ARVALID,
        output S_ARREADY,
        output S_RDATA, S_RRESP, S_RVALID,
        input  S_RREADY
    );

    modport master (
        output S_AWADDR, S_AWPROT, S_AWVALID,
        input  S_AWREADY,
        output S_WDATA, S_WSTRB, S_WVALID,
        input  S_WREADY,
        input  S_BRESP, S_BVALID,
        output S_BREADY,
        output S_ARADDR, S_ARPROT, S_ARVALID,
        input  S_ARREADY,
        input  S_RDATA, S_RRESP, S_RVALID,
        output S_RREADY
    );
endinterface
`default_nettype wire

// File: rtl/axi_lite_slave_regs.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_slave_regs
//  Description : AXI4-Lite responder exposing NUM_REGS 32-bit registers.
//                Write address and write data are accepted independently and
//                in either order. Each channel is parked in a holding
//                register, and the write commits once both halves are held.
//                Reads run in parallel with writes, one outstanding at a time.
//                Decode uses ADDR[15:2] as the word index. Indices at or
//                above NUM_REGS return SLVERR.
//  Ports       : clk      - clock
//                reset_n  - asynchronous active-low reset
//                s_axi    - AXI4-Lite slave modport
//                reg_q    - all register contents, register k at [k*32 +: 32]
//                wr_pulse - one-cycle strobe per register after a good write
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_slave_regs #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  wire                             clk,
    input  wire                             reset_n,
    axi_lite_slave_regs_if.slave            s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0]  reg_q,
    output logic [NUM_REGS-1:0]             wr_pulse
);

    localparam int          c_idx_w    = $clog2(NUM_REGS);
    localparam int          c_nbytes   = DATA_WIDTH / 8;
    localparam logic [13:0] c_num_regs = 14'(NUM_REGS);
    localparam logic [1:0]  c_okay     = 2'b00;
    localparam logic [1:0]  c_slverr   = 2'b10;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // Set at the first clk edge after reset. Keeps every READY low
    // during the cycle in which reset is released.
    logic                    r_rdy_en;

    logic                    r_aw_held;
    logic [13:0]             r_aw_idx;
    logic                    r_w_held;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [c_nbytes-1:0]     r_wstrb;

    logic                    r_bvalid;
    logic [1:0]              r_bresp;

    logic                    r_rvalid;
    logic [1:0]              r_rresp;
    logic [DATA_WIDTH-1:0]   r_rdata;

    logic [NUM_REGS-1:0]     r_wr_pulse;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                    w_awready;
    logic                    w_wready;
    logic                    w_arready;
    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_ar_hs;
    logic                    w_commit;
    logic                    w_aw_in_range;
    logic                    w_wr_en;
    logic [13:0]             w_ar_idx;
    logic                    w_ar_in_range;
    logic [NUM_REGS-1:0]     w_wr_sel;
    logic [DATA_WIDTH-1:0]   w_rd_word;

    // A pending B response blocks new AW/W acceptance. This limits the
    // block to one write in flight, so the holding registers are never
    // overwritten before they commit.
    assign w_awready     = r_rdy_en & ~r_aw_held & ~r_bvalid;
    assign w_wready      = r_rdy_en & ~r_w_held  & ~r_bvalid;
    assign w_arready     = r_rdy_en & ~r_rvalid;

    assign w_aw_hs       = s_axi.S_AWVALID & w_awready;
    assign w_w_hs        = s_axi.S_WVALID  & w_wready;
    assign w_ar_hs       = s_axi.S_ARVALID & w_arready;

    assign w_commit      = r_aw_held & r_w_held & ~r_bvalid;
    assign w_aw_in_range = (r_aw_idx < c_num_regs);
    assign w_wr_en       = w_commit & w_aw_in_range;

    assign w_ar_idx      = s_axi.S_ARADDR[15:2];
    assign w_ar_in_range = (w_ar_idx < c_num_regs);

    // One-hot select of the register being committed. The same vector
    // drives both the byte-lane writes and the wr_pulse strobe.
    always_comb begin
        w_wr_sel = '0;
        if (w_wr_en) begin
            w_wr_sel[r_aw_idx[c_idx_w-1:0]] = 1'b1;
        end
    end

    // Read mux. An index that matches no register yields zero, which is
    // already the required out-of-range read data.
    always_comb begin
        w_rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_ar_idx == 14'(k)) begin
                w_rd_word = reg_q[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Write channel capture, commit and B response
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdy_en   <= 1'b0;
            r_aw_held  <= 1'b0;
            r_aw_idx   <= '0;
            r_w_held   <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= c_okay;
            r_wr_pulse <= '0;
        end else begin
            r_rdy_en   <= 1'b1;
            r_wr_pulse <= w_wr_sel;

            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= s_axi.S_AWADDR[15:2];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_axi.S_WDATA;
                r_wstrb  <= s_axi.S_WSTRB;
            end

            // A handshake cannot coincide with a commit, because both held
            // flags are set and both READYs are therefore low.
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_aw_in_range ? c_okay : c_slverr;
            end else if (r_bvalid && s_axi.S_BREADY) begin
                r_bvalid  <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register bank
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
        logic [DATA_WIDTH-1:0] r_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_q <= '0;
            end else if (w_wr_sel[k]) begin
                for (int b = 0; b < c_nbytes; b++) begin
                    if (r_wstrb[b]) begin
                        r_q[b*8 +: 8] <= r_wdata[b*8 +: 8];
                    end
                end
            end
        end

        assign reg_q[k*DATA_WIDTH +: DATA_WIDTH] = r_q;
    end

    // ------------------------------------------------------------------
    // Read channel. The data is sampled from the register outputs before
    // the edge, so a read that coincides with a commit returns the old
    // value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rvalid <= 1'b0;
            r_rresp  <= c_okay;
            r_rdata  <= '0;
        end else begin
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rresp  <= w_ar_in_range ? c_okay : c_slverr;
                r_rdata  <= w_rd_word;
            end else if (r_rvalid && s_axi.S_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_axi.S_AWREADY = w_awready;
    assign s_axi.S_WREADY  = w_wready;
    assign s_axi.S_ARREADY = w_arready;
    assign s_axi.S_BVALID  = r_bvalid;
    assign s_axi.S_BRESP   = r_bresp;
    assign s_axi.S_RVALID  = r_rvalid;
    assign s_axi.S_RRESP   = r_rresp;
    assign s_axi.S_RDATA   = r_rdata;
    assign wr_pulse        = r_wr_pulse;

    // Address bits outside the word index, and the PROT fields, are
    // intentionally ignored.
    logic w_unused;
    assign w_unused = ^{s_axi.S_AWADDR[ADDR_WIDTH-1:16], s_axi.S_AWADDR[1:0],
                        s_axi.S_ARADDR[ADDR_WIDTH-1:16], s_axi.S_ARADDR[1:0],
                        s_axi.S_AWPROT, s_axi.S_ARPROT};

endmodule
`default_nettype wire
